// File: rtl/alu_sys_pkg.sv
// Shared constants and state encoding for the ALU command controller.
package alu_sys_pkg;

  localparam logic [7:0] CmdOper = 8'hCC;
  localparam logic [7:0] CmdNoop = 8'hDD;

  localparam int unsigned AluTimeout = 4;
  localparam int unsigned TimeoutW   = $clog2(AluTimeout);

  typedef enum logic [2:0] {
    StIdle,
    StWaitA,
    StWaitB,
    StWaitFun,
    StAluExec,
    StWaitRes,
    StSendLo,
    StSendHi
  } state_e;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// RX command bytes, ALU operand/result handshake and TX FIFO write port.
interface alu_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_D;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   ALU_A;
  logic [DATA_WIDTH-1:0]   ALU_B;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    ALU_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic [DATA_WIDTH-1:0]   TX_D;
  logic                    TX_D_VLD;
  logic                    FIFO_FULL;
  logic                    BUSY;
  logic                    ERR;

  modport master (
    input  RX_D, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D, TX_D_VLD, BUSY, ERR
  );

  modport slave (
    output RX_D, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D, TX_D_VLD, BUSY, ERR
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Decodes RX command frames into ALU operations and serialises the 2-byte
// result into the TX FIFO, with a fixed timeout on the ALU response.
module alu_cmd_ctrl
  import alu_sys_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER   = DATA_WIDTH'(CmdOper),
  parameter logic [DATA_WIDTH-1:0] CMD_NOOP   = DATA_WIDTH'(CmdNoop)
) (
  input logic           CLK,
  input logic           RST,
  alu_cmd_ctrl_if.master bus
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [TimeoutW-1:0]     cnt_q, cnt_d;
  logic                    alu_en, tx_vld, err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_fun_q <= alu_fun_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    alu_en    = 1'b0;
    tx_vld    = 1'b0;
    err       = 1'b0;

    // RX strobes are only consumed in the four non-busy states.
    unique case (state_q)
      StIdle: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_D == CMD_OPER)      state_d = StWaitA;
          else if (bus.RX_D == CMD_NOOP) state_d = StWaitFun;
        end
      end
      StWaitA: begin
        if (bus.RX_D_VLD) begin
          alu_a_d = bus.RX_D;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (bus.RX_D_VLD) begin
          alu_b_d = bus.RX_D;
          state_d = StWaitFun;
        end
      end
      StWaitFun: begin
        if (bus.RX_D_VLD) begin
          alu_fun_d = bus.RX_D[FUN_WIDTH-1:0];
          state_d   = StAluExec;
        end
      end
      StAluExec: begin
        alu_en  = 1'b1;
        cnt_d   = '0;
        state_d = StWaitRes;
      end
      StWaitRes: begin
        // A result arriving in the last allowed cycle still wins over the timeout.
        if (bus.ALU_OUT_VLD) begin
          result_d = bus.ALU_OUT;
          state_d  = StSendLo;
        end else if (cnt_q == TimeoutW'(AluTimeout - 1)) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSendLo: begin
        if (!bus.FIFO_FULL) begin
          tx_vld  = 1'b1;
          state_d = StSendHi;
        end
      end
      StSendHi: begin
        if (!bus.FIFO_FULL) begin
          tx_vld  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  assign bus.ALU_A    = alu_a_q;
  assign bus.ALU_B    = alu_b_q;
  assign bus.ALU_FUN  = alu_fun_q;
  assign bus.ALU_EN   = alu_en;
  assign bus.TX_D_VLD = tx_vld;
  assign bus.ERR      = err;
  assign bus.BUSY     = state_q inside {StAluExec, StWaitRes, StSendLo, StSendHi};
  assign bus.TX_D     = (state_q == StSendHi) ? result_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                        (state_q == StSendLo) ? result_q[DATA_WIDTH-1:0] : '0;

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, shall set operand and byte width.
REQ-002 Parameter FUN_WIDTH, default 4, shall set ALU function-code width.
REQ-003 Parameter CMD_OPER, default 8'hCC, shall mean "ALU op with new operands".
REQ-004 Parameter CMD_NOOP, default 8'hDD, shall mean "ALU op reusing stored operands".
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-low.
REQ-007 RX_D  in  DATA_WIDTH  received command/data byte.
REQ-008 RX_D_VLD  in  1  one-cycle strobe qualifying RX_D.
REQ-009 ALU_A, ALU_B  out  DATA_WIDTH each  registered operands to ALU.
REQ-010 ALU_FUN  out  FUN_WIDTH  registered function code (low FUN_WIDTH bits of FUN byte).
REQ-011 ALU_EN  out  1  ALU enable, one-cycle pulse.
REQ-012 ALU_OUT  in  2*DATA_WIDTH  ALU result.
REQ-013 ALU_OUT_VLD  in  1  qualifies ALU_OUT.
REQ-014 TX_D  out  DATA_WIDTH  result byte to TX FIFO.
REQ-015 TX_D_VLD  out  1  one-cycle write strobe for TX_D.
REQ-016 FIFO_FULL  in  1  TX FIFO full; no write while high.
REQ-017 BUSY  out  1  high in ALU_EXEC, WAIT_RES, SEND_LO, SEND_HI.
REQ-018 ERR  out  1  one-cycle pulse on ALU timeout.

Function
REQ-019 FSM states: IDLE, WAIT_A, WAIT_B, WAIT_FUN, ALU_EXEC, WAIT_RES, SEND_LO, SEND_HI.
REQ-020 IDLE: RX_D_VLD with CMD_OPER -> WAIT_A; with CMD_NOOP -> WAIT_FUN; any other byte ignored, stay IDLE.
REQ-021 WAIT_A: on RX_D_VLD store byte into ALU_A -> WAIT_B; WAIT_B: store into ALU_B -> WAIT_FUN.
REQ-022 WAIT_FUN: on RX_D_VLD store RX_D[FUN_WIDTH-1:0] into ALU_FUN -> ALU_EXEC.
REQ-023 ALU_EXEC: assert ALU_EN for exactly one cycle -> WAIT_RES.
REQ-024 WAIT_RES: on ALU_OUT_VLD capture ALU_OUT into internal 16-bit result register -> SEND_LO.
REQ-025 WAIT_RES: if ALU_OUT_VLD absent for 4 cycles after ALU_EN, pulse ERR, -> IDLE, no TX write.
REQ-026 SEND_LO: when FIFO_FULL=0, drive TX_D=result[7:0], pulse TX_D_VLD -> SEND_HI; while FIFO_FULL=1 hold state, TX_D_VLD=0.
REQ-027 SEND_HI: same rule with result[15:8] -> IDLE.
REQ-028 Minimum frame-to-first-TX-write latency: FUN byte strobe +1 ALU_EN, +2 ALU_OUT_VLD, +3 capture, +3 TX_D_VLD for low byte (no backpressure).
REQ-029 RX_D_VLD while BUSY=1 shall be dropped, no state change.
REQ-030 ALU_A/ALU_B shall hold value across frames; CMD_NOOP shall reuse last stored values (0 after reset).
REQ-031 ALU_EN, TX_D_VLD, ERR shall never be high in same cycle.

Reset
REQ-032 RST low shall force, asynchronously, state IDLE; ALU_A, ALU_B, ALU_FUN, result, TX_D, timeout counter to 0; ALU_EN, TX_D_VLD, ERR, BUSY to 0.
REQ-033 Reset mid-frame or mid-send shall abandon the frame; no partial TX write after release.

Structure
REQ-034 State encoding, CMD_OPER/CMD_NOOP values and timeout constant (4) shall live in shared package alu_sys_pkg.
REQ-035 Single optional sub-module alu_cmd_ctrl_tx_ser (2-byte serializer with FIFO_FULL backpressure); otherwise flat.

Verification
REQ-036 RX CC,0x0A,0x05,0x00 (add) -> ALU_A=0x0A, ALU_B=0x05, ALU_FUN=0, one ALU_EN; ALU returns 0x000F -> TX 0x0F then 0x00.
REQ-037 RX CC,0x10,0x10,0x02 then DD,0x00 -> second op uses A=B=0x10; two 2-byte results written, A/B unchanged.
REQ-038 FIFO_FULL held high 5 cycles in SEND_LO -> no TX_D_VLD during hold, low byte written first cycle after release, then high byte.
REQ-039 ALU model never returns ALU_OUT_VLD -> ERR pulse exactly 4 cycles after ALU_EN, state IDLE, no TX write.
REQ-040 Byte 0x55 in IDLE, and extra RX bytes during BUSY -> ignored; next CC frame processed normally.
REQ-041 RST asserted in WAIT_B and again in SEND_HI -> all outputs 0 immediately, no TX_D_VLD after release.
